// File: rtl/keypad_scan_debounce.sv
`timescale 1ns/1ps
// keypad_scan_debounce: 4x4 matrix keypad column scanner with press and release debounce.
// Define KEYPAD_AUTOREPEAT_EN to add auto-repeat strobes while an accepted key stays held.
module keypad_scan_debounce #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 8,
  parameter int REPEAT_DELAY = 200,
  parameter int REPEAT_RATE  = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_CNT);

  if (SCAN_DIV < 4 || DEBOUNCE_CNT < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
    $error("keypad_scan_debounce: parameter out of range");
  end

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED} state_t;
  state_t state;

  logic [3:0]    row_meta;
  logic [3:0]    row_s;
  logic [3:0]    row_low;
  logic [DW-1:0] div;
  logic          tick;
  logic          valid;
  logic [1:0]    row_idx;
  logic [1:0]    row_lat;
  logic [1:0]    col_idx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] rcnt;
  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] rcnt_inc;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW = $clog2(RMAX + 1);
  localparam logic [RW-1:0] RPT_DELAY = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RPT_RATE  = RW'(REPEAT_RATE);
  logic [RW-1:0] rpt;
  logic [RW-1:0] rpt_inc;
  logic          rpt_phase;
  assign rpt_inc = rpt + RW'(1);
`endif

  // Rows idle high through the pull-ups, so the synchroniser resets to all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= 4'hF;
      row_s    <= 4'hF;
    end else begin
      row_meta <= row_in;
      row_s    <= row_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    div <= '0;
    else if (tick) div <= '0;
    else           div <= div + DW'(1);
  end

  assign tick     = (div == DIV_LAST);
  assign row_low  = ~row_s;
  assign valid    = (row_low != 4'd0) && ((row_low & (row_low - 4'd1)) == 4'd0);
  assign cnt_inc  = cnt + CW'(1);
  assign rcnt_inc = rcnt + CW'(1);

  always_comb begin
    row_idx = 2'd0;
    case (row_low)
      4'b0010: row_idx = 2'd1;
      4'b0100: row_idx = 2'd2;
      4'b1000: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
  end

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    code = 4'h0;
    case ({r, c})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hF;  4'hD: code = 4'h0;  4'hE: code = 4'hE;  4'hF: code = 4'hD;
    endcase
    return code;
  endfunction

  // Release returns to SCAN without rotating so the same key can be pressed again at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCAN;
      col_out   <= 4'b1110;
      col_idx   <= 2'd0;
      row_lat   <= 2'd0;
      cnt       <= '0;
      rcnt      <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt       <= '0;
      rpt_phase <= 1'b0;
`endif
    end else begin
      key_valid <= 1'b0;
      if (tick) begin
        case (state)
          SCAN: begin
            if (valid) begin
              row_lat <= row_idx;
              cnt     <= CW'(1);
              state   <= DEBOUNCE;
            end else begin
              col_out <= {col_out[2:0], col_out[3]};
              col_idx <= col_idx + 2'd1;
            end
          end
          DEBOUNCE: begin
            if (valid && row_idx == row_lat) begin
              if (cnt_inc == CNT_DONE) begin
                key_code  <= key_map(row_lat, col_idx);
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                cnt       <= '0;
                rcnt      <= '0;
                state     <= PRESSED;
`ifdef KEYPAD_AUTOREPEAT_EN
                rpt       <= '0;
                rpt_phase <= 1'b0;
`endif
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              cnt     <= '0;
              state   <= SCAN;
              col_out <= {col_out[2:0], col_out[3]};
              col_idx <= col_idx + 2'd1;
            end
          end
          PRESSED: begin
            if (row_s[row_lat]) begin
`ifdef KEYPAD_AUTOREPEAT_EN
              rpt       <= '0;
              rpt_phase <= 1'b0;
`endif
              if (rcnt_inc == CNT_DONE) begin
                key_held <= 1'b0;
                rcnt     <= '0;
                state    <= SCAN;
              end else begin
                rcnt <= rcnt_inc;
              end
            end else begin
              rcnt <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
              if (!rpt_phase && rpt_inc == RPT_DELAY) begin
                key_valid <= 1'b1;
                rpt       <= '0;
                rpt_phase <= 1'b1;
              end else if (rpt_phase && rpt_inc == RPT_RATE) begin
                key_valid <= 1'b1;
                rpt       <= '0;
              end else begin
                rpt <= rpt_inc;
              end
`endif
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
`timescale 1ns/1ps
// tb_keypad_scan_debounce: directed self-checking bench with SCAN_DIV=4, DEBOUNCE_CNT=3.
// Outputs are sampled on the falling edge; ticks fall on the rising edge that rotates col_out.
module tb_keypad_scan_debounce;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 3;
  localparam int REPEAT_DELAY = 5;
  localparam int REPEAT_RATE  = 2;
  localparam int MAX_WAIT     = 60;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row_in = 4'hF;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  int checks = 0;
  int errors = 0;
  int strobes = 0;

  keypad_scan_debounce #(
    .SCAN_DIV    (SCAN_DIV),
    .DEBOUNCE_CNT(DEBOUNCE_CNT),
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .row_in   (row_in),
    .col_out  (col_out),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  // key_valid still shows the previous cycle at the rising edge, so each strobe counts once.
  always @(posedge clk) if (key_valid) strobes++;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic wait_col(input logic [3:0] target, output bit ok);
    int n;
    n = 0;
    while (col_out == target && n < MAX_WAIT) begin @(negedge clk); n++; end
    while (col_out != target && n < MAX_WAIT) begin @(negedge clk); n++; end
    ok = (col_out == target);
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    rst_n = 1'b0;
    row_in = 4'hF;
    repeat (3) @(negedge clk);
    checks++; if (col_out !== 4'b1110) begin errors++; $display("[TB] FAIL reset_col: got %b, expected 1110", col_out); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b, expected 0", key_valid); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("[TB] FAIL reset_held: got %b, expected 0", key_held); end
    checks++; if (key_code !== 4'h0) begin errors++; $display("[TB] FAIL reset_code: got %h, expected 0", key_code); end
    rst_n = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      if (n == 3 || n % 4 == 0) begin
        case (n)
          3:       exp_col = 4'b1110;
          4:       exp_col = 4'b1101;
          8:       exp_col = 4'b1011;
          12:      exp_col = 4'b0111;
          default: exp_col = 4'b1110;
        endcase
        checks++;
        if (col_out !== exp_col) begin errors++; $display("[TB] FAIL free_run_col@%0d: got %b, expected %b", n, col_out, exp_col); end
      end
    end
  endtask

  task automatic test_clean_press();
    bit ok;
    int n;
    int s0;
    wait_col(4'b1101, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL clean_col_wait: got %b, expected 1101", col_out); end
    s0 = strobes;
    row_in = 4'b1011;
    n = 0;
    while (key_valid !== 1'b1 && n < MAX_WAIT) begin @(negedge clk); n++; end
    checks++; if (n != 12) begin errors++; $display("[TB] FAIL clean_latency: got %0d cycles, expected 12", n); end
    checks++; if (key_code !== 4'h8) begin errors++; $display("[TB] FAIL clean_code: got %h, expected 8", key_code); end
    checks++; if (key_held !== 1'b1) begin errors++; $display("[TB] FAIL clean_held: got %b, expected 1", key_held); end
    @(negedge clk);
    checks++; if (key_valid !== 1'b0) begin errors++; $display("[TB] FAIL clean_pulse_width: got %b, expected 0", key_valid); end
    row_in = 4'hF;
    n = 0;
    while (key_held !== 1'b0 && n < MAX_WAIT) begin @(negedge clk); n++; end
    checks++; if (n != 11) begin errors++; $display("[TB] FAIL clean_release_latency: got %0d cycles, expected 11", n); end
    checks++; if (col_out !== 4'b1101) begin errors++; $display("[TB] FAIL clean_no_rotate: got %b, expected 1101", col_out); end
    checks++; if (strobes - s0 != 1) begin errors++; $display("[TB] FAIL clean_strobes: got %0d, expected 1", strobes - s0); end
  endtask

  task automatic test_bounce();
    bit ok;
    int n;
    int s0;
    wait_col(4'b1110, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL bounce_col_wait: got %b, expected 1110", col_out); end
    s0 = strobes;
    for (int j = 0; j < 8; j++) begin
      row_in = (j % 2 == 0) ? 4'b1110 : 4'b1111;
      repeat (4) @(negedge clk);
    end
    row_in = 4'hF;
    repeat (8) @(negedge clk);
    checks++; if (strobes != s0) begin errors++; $display("[TB] FAIL bounce_reject: got %0d strobes, expected 0", strobes - s0); end
    wait_col(4'b1110, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL bounce_col_wait2: got %b, expected 1110", col_out); end
    row_in = 4'b1110;
    n = 0;
    while (key_valid !== 1'b1 && n < MAX_WAIT) begin @(negedge clk); n++; end
    checks++; if (n != 12) begin errors++; $display("[TB] FAIL bounce_hold_latency: got %0d cycles, expected 12", n); end
    checks++; if (key_code !== 4'h1) begin errors++; $display("[TB] FAIL bounce_hold_code: got %h, expected 1", key_code); end
    row_in = 4'hF;
    n = 0;
    while (key_held !== 1'b0 && n < MAX_WAIT) begin @(negedge clk); n++; end
    checks++; if (strobes - s0 != 1) begin errors++; $display("[TB] FAIL bounce_hold_strobes: got %0d, expected 1", strobes - s0); end
  endtask

  task automatic test_ghosting();
    bit ok;
    int s0;
    logic [3:0] exp_col;
    wait_col(4'b1110, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL ghost_col_wait: got %b, expected 1110", col_out); end
    s0 = strobes;
    row_in = 4'b1100;
    exp_col = 4'b1110;
    for (int k = 1; k <= 4; k++) begin
      repeat (4) @(negedge clk);
      exp_col = {exp_col[2:0], exp_col[3]};
      checks++;
      if (col_out !== exp_col) begin errors++; $display("[TB] FAIL ghost_scan@%0d: got %b, expected %b", k, col_out, exp_col); end
    end
    row_in = 4'hF;
    checks++; if (strobes != s0) begin errors++; $display("[TB] FAIL ghost_strobes: got %0d, expected 0", strobes - s0); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("[TB] FAIL ghost_held: got %b, expected 0", key_held); end
  endtask

  task automatic test_mapping();
    logic [3:0] map_exp [16];
    logic [3:0] colp;
    logic [3:0] rowp;
    bit ok;
    int n;
    int s0;
    map_exp = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                4'h7, 4'h8, 4'h9, 4'hC, 4'hF, 4'h0, 4'hE, 4'hD};
    for (int idx = 0; idx < 16; idx++) begin
      colp = ~(4'b0001 << (idx % 4));
      rowp = ~(4'b0001 << (idx / 4));
      wait_col(colp, ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL map_col_wait[%0d]: got %b, expected %b", idx, col_out, colp); end
      s0 = strobes;
      row_in = rowp;
      n = 0;
      while (key_valid !== 1'b1 && n < MAX_WAIT) begin @(negedge clk); n++; end
      checks++; if (n >= MAX_WAIT) begin errors++; $display("[TB] FAIL map_timeout[%0d]: got no strobe, expected one", idx); end
      checks++; if (key_code !== map_exp[idx]) begin errors++; $display("[TB] FAIL map_code[%0d]: got %h, expected %h", idx, key_code, map_exp[idx]); end
      row_in = 4'hF;
      n = 0;
      while (key_held !== 1'b0 && n < MAX_WAIT) begin @(negedge clk); n++; end
      checks++; if (strobes - s0 != 1) begin errors++; $display("[TB] FAIL map_strobes[%0d]: got %0d, expected 1", idx, strobes - s0); end
    end
  endtask

  task automatic test_long_hold();
    bit ok;
    int n;
    int offs[$];
    wait_col(4'b1101, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL hold_col_wait: got %b, expected 1101", col_out); end
    row_in = 4'b1101;
    n = 0;
    while (key_valid !== 1'b1 && n < MAX_WAIT) begin @(negedge clk); n++; end
    checks++; if (key_code !== 4'h5) begin errors++; $display("[TB] FAIL hold_code: got %h, expected 5", key_code); end
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (key_valid === 1'b1) offs.push_back(k);
      if (k == 48) row_in = 4'hF;
    end
    checks++; if (key_held !== 1'b0) begin errors++; $display("[TB] FAIL hold_release: got %b, expected 0", key_held); end
`ifdef KEYPAD_AUTOREPEAT_EN
    begin
      int exp_off[4];
      exp_off = '{20, 28, 36, 44};
      checks++; if (offs.size() != 4) begin errors++; $display("[TB] FAIL repeat_count: got %0d, expected 4", offs.size()); end
      for (int i = 0; i < 4; i++) begin
        if (i < offs.size()) begin
          checks++;
          if (offs[i] != exp_off[i]) begin errors++; $display("[TB] FAIL repeat_offset[%0d]: got %0d, expected %0d", i, offs[i], exp_off[i]); end
        end
      end
    end
`else
    checks++; if (offs.size() != 0) begin errors++; $display("[TB] FAIL hold_single_strobe: got %0d extra strobes, expected 0", offs.size()); end
`endif
  endtask

  task automatic test_reset_mid_debounce();
    bit ok;
    int s0;
    wait_col(4'b1011, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL midrst_col_wait: got %b, expected 1011", col_out); end
    row_in = 4'b1101;
    repeat (6) @(negedge clk);
    checks++; if (col_out !== 4'b1011) begin errors++; $display("[TB] FAIL midrst_col_held: got %b, expected 1011", col_out); end
    s0 = strobes;
    rst_n = 1'b0;
    #1;
    checks++; if (col_out !== 4'b1110) begin errors++; $display("[TB] FAIL midrst_col: got %b, expected 1110", col_out); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid: got %b, expected 0", key_valid); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("[TB] FAIL midrst_held: got %b, expected 0", key_held); end
    checks++; if (key_code !== 4'h0) begin errors++; $display("[TB] FAIL midrst_code: got %h, expected 0", key_code); end
    row_in = 4'hF;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    checks++; if (strobes != s0) begin errors++; $display("[TB] FAIL midrst_strobes: got %0d, expected 0", strobes - s0); end
  endtask

  initial begin
    $display("[TB] keypad_scan_debounce bench start");
    test_reset();
    test_clean_press();
    test_bounce();
    test_ghosting();
    test_mapping();
    test_long_hold();
    test_reset_mid_debounce();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scan_debounce.md
Name: keypad_scan_debounce

Overview:
Upstream front end for the calculator datapath. Drives the columns of a 4x4 matrix keypad and samples the rows through a synchroniser. It debounces both press and release. It emits one single-cycle key_valid strobe per debounced press, with a 4-bit key code matching the calculator's key encoding (0-9 digits, A plus, B minus, C multiply, D divide, E clear, F decimal point). Column outputs go directly to the keypad pins; key_code and key_valid feed the calculator FSM.

Parameters:
SCAN_DIV, 1000, clk cycles per scan tick (column dwell time); must be >= 4.
DEBOUNCE_CNT, 8, consecutive identical tick samples needed to accept a press, and separately a release; must be >= 2.
REPEAT_DELAY, 200, ticks held before the first auto-repeat (used only with KEYPAD_AUTOREPEAT_EN).
REPEAT_RATE, 50, ticks between auto-repeats (used only with KEYPAD_AUTOREPEAT_EN).

Ports:
clk  in  1  system clock
rst_n  in  1  reset
row_in  in  4  keypad rows, active-low, external pull-ups
col_out  out  4  keypad column drive, active-low one-hot
key_code  out  4  code of last accepted key; held stable until the next accept
key_valid  out  1  one-cycle strobe for each accepted press
key_held  out  1  high while the accepted key is still debounced-pressed

Behaviour:
- Clock and reset:
  - Reset rst_n is asynchronous and active-low; clock is clk.
  - Reset values: col_out=4'b1110, key_code=0, key_valid=0, key_held=0, state=SCAN, all counters 0, synchroniser flops 4'b1111.
  - Asserting reset mid-operation aborts any debounce immediately. key_valid drops in the same instant; no strobe follows reset release until a full debounce completes.
- Synchroniser: row_in passes through 2 flops; row_s denotes the synchronised value. It adds 2 cycles of latency.
- Tick:
  - div counter runs 0..SCAN_DIV-1 and wraps; tick=1 when div==SCAN_DIV-1.
  - Rows are sampled only on tick, which gives SCAN_DIV-1 cycles of settling after a column change.
- Valid sample: exactly one bit of row_s is 0. A sample with zero or multiple low rows is "no key".
- FSM states:
  - SCAN:
    - On tick with a valid sample: latch col/row index, set cnt=1, go to DEBOUNCE. col_out is held.
    - Otherwise on tick: rotate col_out left (1110 -> 1101 -> 1011 -> 0111 -> 1110).
  - DEBOUNCE (column held):
    - On tick, sample identical to the latched one: cnt++.
    - When cnt reaches DEBOUNCE_CNT: register key_code from the map, pulse key_valid for the next cycle only, set key_held=1, cnt=0, go to PRESSED.
    - On tick, sample differs or no key: cnt=0, go to SCAN, rotate column.
  - PRESSED:
    - On tick, latched row reads high: rcnt++.
    - On tick, row reads low again: rcnt=0.
    - When rcnt reaches DEBOUNCE_CNT: key_held=0, go to SCAN. The column is not rotated, so the same key can be re-pressed.
    - No new key_valid is generated in this state (except with auto-repeat).
- Key map (row r = bit index of the low row, c = column index):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: F 0 E D
- Latency: for a press first seen at tick t0, key_valid is high in the cycle after tick t0+(DEBOUNCE_CNT-1)*SCAN_DIV. This excludes the 2-cycle synchroniser delay.
- Key presses on other columns are not observed while in DEBOUNCE or PRESSED.
- key_code is only updated at accept; it does not change on release.

Optional Feature:
KEYPAD_AUTOREPEAT_EN:
- Defined: in PRESSED, a repeat counter counts ticks while the key stays pressed.
  - At REPEAT_DELAY ticks, key_valid pulses once with the same key_code; thereafter it pulses every REPEAT_RATE ticks.
  - Any release-sample tick, or leaving PRESSED, clears the repeat counter.
- Undefined: repeat logic is absent; exactly one key_valid per press.

Test Plan:
- Reset check: reset -> col_out=1110, key_valid=0, key_held=0, key_code=0. Free run with row_in=1111 and SCAN_DIV=4 -> col_out rotates every 4 cycles through 1110, 1101, 1011, 0111, 1110.
- Clean press (SCAN_DIV=4, DEBOUNCE_CNT=3): hold row_in=1011 when col_out=1101 -> exactly one key_valid with key_code=8, 9 cycles after the detecting tick. key_held=1 until release is debounced 3 ticks later.
- Bounce rejection: toggle row0 low/high each tick on col0 -> no key_valid. Then hold it low for 3 ticks -> one key_valid with key_code=1.
- Ghosting: row_in=1100 on any column -> treated as no key, scan continues, no key_valid.
- Mapping sweep: press each of the 16 positions in turn -> codes 1,2,3,A,4,5,6,B,7,8,9,C,F,0,E,D, each with exactly one strobe. Assert rst_n low mid-DEBOUNCE -> no strobe, and col_out=1110 immediately.
- With KEYPAD_AUTOREPEAT_EN (REPEAT_DELAY=5, REPEAT_RATE=2): hold key 5 for 12 ticks after accept -> strobes at accept, +5, +7, +9 and +11 ticks.
